// File: rtl/board_io_ctrl.sv
// Board-level I/O and reset conditioning between the FPGA pins and the SoC core.
// Synchronises and debounces switches and buttons, emits one-cycle button-press
// pulses, sequences the core reset from PLL lock, and drives LEDs through a
// brightness-controlled PWM.
module board_io_ctrl #(
   parameter int N_SW            = 16,
   parameter int N_BTN           = 5,
   parameter int N_LED           = 16,
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int RST_HOLD_CYCLES = 16,
   parameter int PWM_W           = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               pll_locked_i,
   output logic               sys_rst_o,
   input  logic [N_SW-1:0]    sw_i,
   input  logic [N_BTN-1:0]   btn_i,
   output logic [N_SW-1:0]    sw_o,
   output logic [N_BTN-1:0]   btn_o,
   output logic [N_BTN-1:0]   btn_rise_o,
   input  logic [N_LED-1:0]   led_i,
   input  logic [PWM_W-1:0]   led_bright_i,
   output logic [N_LED-1:0]   led_o
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
   localparam logic [PWM_W-1:0] PWM_FULL = '1;

   typedef enum logic [1:0] {
      RST_ASSERT,
      RST_HOLD,
      RUN
   } rst_state_t;

   logic [N_SW-1:0]   sw_meta, sw_sync;
   logic [N_BTN-1:0]  btn_meta, btn_sync;
   logic              lock_meta, lock_sync;
   logic [N_BTN-1:0]  btn_prev;
   rst_state_t        state, state_next;
   logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;
   logic [PWM_W-1:0]  pwm_cnt;
   logic              pwm_on;

   // Two-flop synchronisers for every asynchronous pin, including PLL lock
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sw_meta   <= '0;
         sw_sync   <= '0;
         btn_meta  <= '0;
         btn_sync  <= '0;
         lock_meta <= 1'b0;
         lock_sync <= 1'b0;
      end else begin
         sw_meta   <= sw_i;
         sw_sync   <= sw_meta;
         btn_meta  <= btn_i;
         btn_sync  <= btn_meta;
         lock_meta <= pll_locked_i;
         lock_sync <= lock_meta;
      end
   end

   genvar gi;

   // Switch debounce: a new level is accepted only after it has been seen on
   // DEBOUNCE_CYCLES consecutive edges; any return to the old level restarts the count
   for (gi = 0; gi < N_SW; gi++) begin : g_sw_db
      logic [DB_W-1:0] cnt;
      logic            stable;
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            cnt    <= '0;
            stable <= 1'b0;
         end else if (sw_sync[gi] == stable) begin
            cnt <= '0;
         end else if (cnt == DB_LAST) begin
            stable <= sw_sync[gi];
            cnt    <= '0;
         end else begin
            cnt <= cnt + DB_W'(1);
         end
      end
      assign sw_o[gi] = stable;
   end

   // Button debounce, same acceptance rule as the switches
   for (gi = 0; gi < N_BTN; gi++) begin : g_btn_db
      logic [DB_W-1:0] cnt;
      logic            stable;
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            cnt    <= '0;
            stable <= 1'b0;
         end else if (btn_sync[gi] == stable) begin
            cnt <= '0;
         end else if (cnt == DB_LAST) begin
            stable <= btn_sync[gi];
            cnt    <= '0;
         end else begin
            cnt <= cnt + DB_W'(1);
         end
      end
      assign btn_o[gi] = stable;
   end

   // Rising-edge pulses on the debounced buttons, one cycle after the level rises
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         btn_prev   <= '0;
         btn_rise_o <= '0;
      end else begin
         btn_prev   <= btn_o;
         btn_rise_o <= btn_o & ~btn_prev;
      end
   end

   // Reset sequencer state register; sys_rst_o follows the next state so lock
   // loss asserts the core reset in the same update that leaves RUN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= RST_ASSERT;
         hold_cnt  <= '0;
         sys_rst_o <= 1'b1;
      end else begin
         state     <= state_next;
         hold_cnt  <= hold_cnt_next;
         sys_rst_o <= (state_next != RUN);
      end
   end

   // Reset sequencer next-state: wait for lock, hold for RST_HOLD_CYCLES, then run
   always_comb begin
      state_next    = state;
      hold_cnt_next = hold_cnt;
      case (state)
         RST_ASSERT: begin
            if (lock_sync) begin
               state_next    = RST_HOLD;
               hold_cnt_next = '0;
            end
         end
         RST_HOLD: begin
            if (!lock_sync) begin
               state_next = RST_ASSERT;
            end else if (hold_cnt == HOLD_LAST) begin
               state_next = RUN;
            end else begin
               hold_cnt_next = hold_cnt + HOLD_W'(1);
            end
         end
         RUN: begin
            if (!lock_sync) begin
               state_next = RST_ASSERT;
            end
         end
         default: begin
            state_next = RST_ASSERT;
         end
      endcase
   end

   // Full brightness bypasses the counter compare so there is no dark cycle at wrap
   assign pwm_on = (led_bright_i == PWM_FULL) || (pwm_cnt < led_bright_i);

   // Free-running PWM counter and registered LED drive
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pwm_cnt <= '0;
         led_o   <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_W'(1);
         led_o   <= led_i & {N_LED{pwm_on}};
      end
   end

endmodule

// File: tb/tb_board_io_ctrl.sv
// Self-checking bench for board_io_ctrl with short debounce and the default
// reset hold, comparing against a behavioural model every cycle plus
// hand-computed directed expectations.
module tb_board_io_ctrl;

   localparam int N_SW  = 16;
   localparam int N_BTN = 5;
   localparam int N_LED = 16;
   localparam int D     = 8;
   localparam int H     = 16;
   localparam int W     = 4;

   logic              clk;
   logic              rst_i;
   logic              pll_locked_i;
   logic              sys_rst_o;
   logic [N_SW-1:0]   sw_i;
   logic [N_BTN-1:0]  btn_i;
   logic [N_SW-1:0]   sw_o;
   logic [N_BTN-1:0]  btn_o;
   logic [N_BTN-1:0]  btn_rise_o;
   logic [N_LED-1:0]  led_i;
   logic [W-1:0]      led_bright_i;
   logic [N_LED-1:0]  led_o;

   int checks = 0;
   int errors = 0;

   board_io_ctrl #(
      .N_SW(N_SW),
      .N_BTN(N_BTN),
      .N_LED(N_LED),
      .DEBOUNCE_CYCLES(D),
      .RST_HOLD_CYCLES(H),
      .PWM_W(W)
   ) dut (
      .clk_i(clk),
      .rst_i(rst_i),
      .pll_locked_i(pll_locked_i),
      .sys_rst_o(sys_rst_o),
      .sw_i(sw_i),
      .btn_i(btn_i),
      .sw_o(sw_o),
      .btn_o(btn_o),
      .btn_rise_o(btn_rise_o),
      .led_i(led_i),
      .led_bright_i(led_bright_i),
      .led_o(led_o)
   );

   // 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Behavioural model: pin histories, a lock run-length and a PWM phase
   logic [N_SW-1:0]  sw_hist  [0:D+1];
   logic [N_BTN-1:0] btn_hist [0:D+1];
   logic             lock_hist [0:2];
   logic [N_SW-1:0]  m_sw;
   logic [N_BTN-1:0] m_btn, m_btn_prev, m_rise;
   logic             m_sys_rst;
   logic [N_LED-1:0] m_led;
   int               lock_run;
   int               pwm_phase;
   bit               model_valid = 1'b0;

   // Model update on each active edge; inputs are stable here because they change 1 ns after the edge
   always @(posedge clk) begin
      if (rst_i) begin
         for (int i = 0; i <= D + 1; i++) begin
            sw_hist[i]  = '0;
            btn_hist[i] = '0;
         end
         for (int i = 0; i < 3; i++) lock_hist[i] = 1'b0;
         m_sw        = '0;
         m_btn       = '0;
         m_btn_prev  = '0;
         m_rise      = '0;
         m_sys_rst   = 1'b1;
         m_led       = '0;
         lock_run    = 0;
         pwm_phase   = 0;
         model_valid = 1'b1;
      end else begin
         for (int i = D + 1; i > 0; i--) begin
            sw_hist[i]  = sw_hist[i-1];
            btn_hist[i] = btn_hist[i-1];
         end
         sw_hist[0]   = sw_i;
         btn_hist[0]  = btn_i;
         lock_hist[2] = lock_hist[1];
         lock_hist[1] = lock_hist[0];
         lock_hist[0] = pll_locked_i;

         m_rise     = m_btn & ~m_btn_prev;
         m_btn_prev = m_btn;

         // A bit flips once the D most recent synchronised samples all disagree with it
         for (int b = 0; b < N_SW; b++) begin
            bit flip;
            flip = 1'b1;
            for (int j = 2; j <= D + 1; j++) if (sw_hist[j][b] == m_sw[b]) flip = 1'b0;
            if (flip) m_sw[b] = ~m_sw[b];
         end
         for (int b = 0; b < N_BTN; b++) begin
            bit flip;
            flip = 1'b1;
            for (int j = 2; j <= D + 1; j++) if (btn_hist[j][b] == m_btn[b]) flip = 1'b0;
            if (flip) m_btn[b] = ~m_btn[b];
         end

         // Core runs once H+1 consecutive synchronised lock samples have been high
         if (lock_hist[2]) lock_run = lock_run + 1;
         else lock_run = 0;
         if (lock_run > 1000) lock_run = 1000;
         m_sys_rst = (lock_run < H + 1);

         if (led_bright_i == 4'd15 || pwm_phase < int'(led_bright_i)) m_led = led_i;
         else m_led = '0;
         pwm_phase = (pwm_phase + 1) % 16;
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (model_valid) begin
         check_output("sys_rst_o", 32'(sys_rst_o), 32'(m_sys_rst));
         check_output("sw_o", 32'(sw_o), 32'(m_sw));
         check_output("btn_o", 32'(btn_o), 32'(m_btn));
         check_output("btn_rise_o", 32'(btn_rise_o), 32'(m_rise));
         check_output("led_o", 32'(led_o), 32'(m_led));
      end
   end

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus;
      int n;
      int cnt;
      int first;
      int pulses;
      int rise_cycles;
      logic [N_BTN-1:0] rise_val;

      // Reset held with lock already present
      rst_i = 1'b1; pll_locked_i = 1'b1;
      sw_i = '0; btn_i = '0; led_i = '0; led_bright_i = '0;
      wait_edges(5);
      check_output("reset_sys_rst", 32'(sys_rst_o), 32'd1);
      check_output("reset_sw", 32'(sw_o), 32'd0);
      check_output("reset_btn", 32'(btn_o), 32'd0);
      check_output("reset_led", 32'(led_o), 32'd0);

      // Release: core reset falls 19 edges later and stays low
      rst_i = 1'b0;
      n = 0;
      while (n < 40 && sys_rst_o !== 1'b0) begin
         wait_edges(1);
         n++;
      end
      check_output("sys_rst_fall_edges", 32'(n), 32'd19);
      cnt = 0;
      repeat (10) begin
         wait_edges(1);
         if (sys_rst_o !== 1'b0) cnt++;
      end
      check_output("sys_rst_stays_low", 32'(cnt), 32'd0);

      // One-cycle lock loss: reset rises 3 edges later, full hold restarts
      pll_locked_i = 1'b0;
      n = 0;
      while (n < 10 && sys_rst_o !== 1'b1) begin
         wait_edges(1);
         n++;
         if (n == 1) pll_locked_i = 1'b1;
      end
      check_output("lock_loss_rise_edges", 32'(n), 32'd3);
      while (n < 60 && sys_rst_o !== 1'b0) begin
         wait_edges(1);
         n++;
      end
      check_output("lock_loss_fall_edges", 32'(n), 32'd20);

      // Glitch of 7 cycles on btn[0] is rejected
      btn_i = 5'b00001;
      cnt = 0; pulses = 0;
      for (int i = 0; i < 30; i++) begin
         wait_edges(1);
         if (i == 6) btn_i = '0;
         if (btn_o[0] !== 1'b0) cnt++;
         if (btn_rise_o !== '0) pulses++;
      end
      check_output("glitch_btn_level", 32'(cnt), 32'd0);
      check_output("glitch_btn_pulse", 32'(pulses), 32'd0);

      // Clean press on btn[2]: level at edge 10, single pulse after it
      btn_i = 5'b00100;
      first = 0; pulses = 0;
      for (int i = 1; i <= 20; i++) begin
         wait_edges(1);
         if (btn_o[2] === 1'b1 && first == 0) first = i;
         if (btn_rise_o[2] === 1'b1) pulses++;
      end
      check_output("press_level_edge", 32'(first), 32'd10);
      check_output("press_pulse_count", 32'(pulses), 32'd1);

      // Release: level drops after 10 edges, no pulse
      btn_i = '0;
      n = 0; pulses = 0;
      while (n < 30 && btn_o[2] !== 1'b0) begin
         wait_edges(1);
         n++;
         if (btn_rise_o !== '0) pulses++;
      end
      repeat (5) begin
         wait_edges(1);
         if (btn_rise_o !== '0) pulses++;
      end
      check_output("release_level_edges", 32'(n), 32'd10);
      check_output("release_pulse_count", 32'(pulses), 32'd0);

      // Simultaneous buttons and a switch pattern
      btn_i = 5'b10101;
      sw_i  = 16'hA5C3;
      first = 0; rise_cycles = 0; rise_val = '0;
      for (int i = 1; i <= 20; i++) begin
         wait_edges(1);
         if (sw_o === 16'hA5C3 && first == 0) first = i;
         if (btn_rise_o !== '0) begin
            rise_cycles++;
            rise_val = btn_rise_o;
         end
      end
      check_output("sw_pattern_edge", 32'(first), 32'd10);
      check_output("multi_rise_cycles", 32'(rise_cycles), 32'd1);
      check_output("multi_rise_value", 32'(rise_val), 32'h15);
      btn_i = '0;
      wait_edges(12);

      // PWM brightness 0: always dark
      led_i = 16'hFFFF;
      led_bright_i = 4'd0;
      wait_edges(1);
      cnt = 0;
      repeat (32) begin
         wait_edges(1);
         if (led_o !== 16'h0000) cnt++;
      end
      check_output("pwm_b0_lit", 32'(cnt), 32'd0);

      // Brightness 5: exactly 5 lit cycles in any 16
      led_bright_i = 4'd5;
      wait_edges(1);
      cnt = 0;
      repeat (16) begin
         wait_edges(1);
         if (led_o === 16'hFFFF) cnt++;
      end
      check_output("pwm_b5_lit", 32'(cnt), 32'd5);

      // Brightness 15: permanently lit
      led_bright_i = 4'd15;
      wait_edges(1);
      cnt = 0;
      repeat (16) begin
         wait_edges(1);
         if (led_o === 16'hFFFF) cnt++;
      end
      check_output("pwm_b15_lit", 32'(cnt), 32'd16);

      // Pattern change appears one cycle later
      led_i = 16'h00F0;
      wait_edges(1);
      check_output("led_pattern", 32'(led_o), 32'h00F0);
      wait_edges(2);
   endtask

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      apply_stimulus();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/board_io_ctrl.md
Name: board_io_ctrl

Overview:
- Parametrised board-level I/O and reset conditioning block, placed between FPGA pins and the sigma SoC instance in board top-levels.
- Replaces the fixed 16-switch/16-LED wiring and raw reset/lock gating.
- Generates a sequenced core reset from the PLL lock, synchronises and debounces switches and buttons, and emits one-cycle button-press pulses for IRQ inputs.
- Drives LEDs with a registered, brightness-controlled PWM.

Parameters:
- N_SW, 16, number of slide switches.
- N_BTN, 5, number of push buttons.
- N_LED, 16, number of LEDs.
- DEBOUNCE_CYCLES, 100000, consecutive stable cycles required to accept an input change. Must be >= 1.
- RST_HOLD_CYCLES, 16, cycles sys_rst_o stays high after reset release and PLL lock. Must be >= 1.
- PWM_W, 4, width of the LED brightness control and PWM counter.

Ports:
- clk_i, input, 1, system clock (PLL output).
- rst_i, input, 1, synchronous active-high reset.
- pll_locked_i, input, 1, PLL lock indication; treated as asynchronous and synchronised internally.
- sys_rst_o, input-free output, 1, sequenced synchronous active-high reset for the core.
- sw_i, input, N_SW, raw switch pins.
- btn_i, input, N_BTN, raw button pins, active-high.
- sw_o, output, N_SW, debounced switch levels.
- btn_o, output, N_BTN, debounced button levels.
- btn_rise_o, output, N_BTN, one-cycle pulse per debounced 0->1 button transition.
- led_i, input, N_LED, LED pattern from the core.
- led_bright_i, input, PWM_W, global LED brightness.
- led_o, output, N_LED, LED pins.

Behaviour:
- **Clocking and reset:** single clock domain; all state is reset synchronously by rst_i.
- **Reset values:**
  - sys_rst_o = 1.
  - sw_o, btn_o, btn_rise_o, led_o = 0.
  - All synchroniser flops, debounce counters and the PWM counter = 0.
- **Input synchronisation:** every bit of sw_i, btn_i and pll_locked_i passes through a 2-flop synchroniser.
- **Debounce (one independent counter per bit, width clog2(DEBOUNCE_CYCLES+1)):**
  - If the synchronised value equals the stable value: counter <= 0.
  - Otherwise, if counter == DEBOUNCE_CYCLES-1: stable <= synchronised value and counter <= 0.
  - Otherwise: counter <= counter+1.
  - Any return to the stable value before the threshold clears the counter, so glitches shorter than DEBOUNCE_CYCLES are rejected.
  - Latency from a pin change to the output change is 2+DEBOUNCE_CYCLES clock edges.
- **Button pulses:** btn_rise_o[i] = 1 for exactly one cycle, in the cycle after btn_o[i] goes 0->1. No pulse on 1->0. Multiple bits may pulse in the same cycle.
- **Reset sequencer FSM (states RST_ASSERT, RST_HOLD, RUN):**
  - RST_ASSERT: sys_rst_o = 1. Moves to RST_HOLD when the synchronised lock = 1; the hold counter loads 0.
  - RST_HOLD: sys_rst_o = 1 and the hold counter increments. Moves to RUN when the counter reaches RST_HOLD_CYCLES-1.
  - RUN: sys_rst_o = 0.
  - Lock loss (synchronised lock = 0) in RST_HOLD or RUN returns to RST_ASSERT at the next edge, with sys_rst_o = 1 in that same registered update.
  - rst_i forces RST_ASSERT from any state.
  - sys_rst_o is a registered output. It falls exactly 2 (sync) + 1 + RST_HOLD_CYCLES edges after lock rises with rst_i low.
- **PWM:**
  - Free-running counter pwm_cnt of PWM_W bits, wrapping from 2^PWM_W-1 to 0.
  - on = (led_bright_i == all-ones) | (pwm_cnt < led_bright_i).
  - led_o <= led_i & {N_LED{on}}, registered, giving 1-cycle latency.
  - Brightness 0 keeps LEDs permanently off. All-ones keeps them permanently on (no gap cycle). Brightness b otherwise gives b on-cycles per 2^PWM_W.
  - led_bright_i changes take effect at the next cycle, without waiting for the wrap.
- **During sys_rst_o = 1:** debounce and PWM keep running. Only rst_i clears them.
- **Vector widths:** parameters are independent; N_BTN=1 and N_SW=1 must elaborate.

Test Plan:
- **Reset sequencing (RST_HOLD_CYCLES=16):** rst_i 1 for 5 cycles, pll_locked_i=1 throughout -> sys_rst_o=1 until 19 edges after rst_i falls, then 0 and stays 0.
- **Lock loss:** pll_locked_i drops for 1 cycle while in RUN -> sys_rst_o rises 3 edges later (2 sync + 1 register) and the full 16-cycle hold restarts after lock returns.
- **Glitch rejection (DEBOUNCE_CYCLES=8):** btn_i[0] high for 7 cycles, then low -> btn_o[0] stays 0 and btn_rise_o stays 0.
- **Clean press:** btn_i[2] held high for 20 cycles -> btn_o[2]=1 at edge 10, btn_rise_o[2]=1 for exactly one cycle after it. Release -> btn_o[2]=0 after 10 edges and no pulse.
- **Simultaneous inputs:** btn_i=5'b10101 applied together -> btn_rise_o=5'b10101 in a single cycle. sw_i=16'hA5C3 -> sw_o=16'hA5C3 after 10 edges.
- **PWM (PWM_W=4, led_i=16'hFFFF):**
  - Brightness 0 -> led_o always 0.
  - Brightness 5 -> led_o=16'hFFFF for exactly 5 of every 16 cycles.
  - Brightness 15 -> led_o constantly 16'hFFFF.
  - led_i=16'h00F0 at brightness 15 -> led_o=16'h00F0 one cycle later.
